// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V core front end: fetch entry layout, fetch FSM states
// and the NOP used to pad a faulting fetch.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH_RUN        = 2'd0,
        FETCH_FAULT_PEND = 2'd1,
        FETCH_HALT       = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries between instruction memory and decode.
// The head is read straight from storage, so everything decode sees is registered.
module fetch_skid_fifo
    import riscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   occ_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (occ_q != 2'd0);
        do_push  = push_i && ((occ_q != 2'd2) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        // A flush wins over a same-cycle push so a discarded response never lands.
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            if (!flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues reads to instruction memory and
// tags them with an epoch so redirects can drop stale responses.
module if_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    output logic [IMEM_AW-1:0] imem_address,
    output logic               imem_chipselect,
    output logic               imem_clken,
    output logic               imem_write,
    output logic               imem_debugaccess,
    output logic [3:0]         imem_byteenable,
    output logic [31:0]        imem_writedata,
    input  logic [31:0]        imem_readdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_instr,
    output logic               out_fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         epoch_q, epoch_d;
    logic         inflight_q, inflight_d;
    logic         inflight_epoch_q, inflight_epoch_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;

    logic         pop, push, issue;
    logic [1:0]   occ;
    logic [2:0]   slots_used;
    fetch_entry_t push_entry, head;

    assign pop        = out_valid && out_ready;
    assign slots_used = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue      = (state_q == FETCH_RUN) && !redirect_valid && !reset_reset
                        && (slots_used < 3'd2);

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (state_q == FETCH_FAULT_PEND) begin
            push       = 1'b1;
            push_entry = '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1};
        end else if (inflight_q && (inflight_epoch_q == epoch_q)) begin
            push       = 1'b1;
            push_entry = '{pc: inflight_pc_q, instr: imem_readdata, fault: 1'b0};
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        epoch_d          = epoch_q;
        inflight_d       = issue;
        inflight_epoch_d = epoch_q;
        inflight_pc_d    = pc_q;
        if (redirect_valid) begin
            epoch_d = ~epoch_q;
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] != 2'b00) ? FETCH_FAULT_PEND : FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_RUN:        if (issue) pc_d = pc_q + 32'd4;
                FETCH_FAULT_PEND: state_d = FETCH_HALT;
                FETCH_HALT:       state_d = FETCH_HALT;
                default:          state_d = FETCH_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q          <= FETCH_RUN;
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            inflight_pc_q    <= inflight_pc_d;
        end
    end

    fetch_skid_fifo u_skid (
        .clk_i       (clk_clk),
        .rst_i       (reset_reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .occ_o       (occ)
    );

    assign out_valid        = (occ != 2'd0);
    assign out_pc           = head.pc;
    assign out_instr        = head.instr;
    assign out_fault        = head.fault;
    assign imem_address     = pc_q[IMEM_AW+1:2];
    assign imem_chipselect  = issue;
    assign imem_clken       = 1'b1;
    assign imem_write       = 1'b0;
    assign imem_debugaccess = 1'b0;
    assign imem_byteenable  = 4'hF;
    assign imem_writedata   = 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// back-pressure, redirects and resets, checked against a PC-stream reference model.
module tb_if_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [9:0]  imem_address;
    logic        imem_chipselect;
    logic        imem_clken;
    logic        imem_write;
    logic        imem_debugaccess;
    logic [3:0]  imem_byteenable;
    logic [31:0] imem_writedata;
    logic [31:0] imem_readdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic stallWindow = 1'b0;

    exp_t        expQ[$];
    logic [31:0] streamPc;
    logic [31:0] issuePc;
    logic        halted = 1'b0;
    logic        pendFirst = 1'b0;
    int          firstDue = 0;
    logic        prevStall = 1'b0;
    logic [31:0] savedPc;
    logic [31:0] savedInstr;
    logic        savedFault;

    if_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .imem_address     (imem_address),
        .imem_chipselect  (imem_chipselect),
        .imem_clken       (imem_clken),
        .imem_write       (imem_write),
        .imem_debugaccess (imem_debugaccess),
        .imem_byteenable  (imem_byteenable),
        .imem_writedata   (imem_writedata),
        .imem_readdata    (imem_readdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .out_fault        (out_fault)
    );

    // Free-running clock; cycle 0 is the first cycle with reset released.
    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= reset_reset ? 0 : cyc + 1;

    // Instruction memory: word i holds A000_0000+i, one-cycle read latency.
    always @(posedge clk_clk)
        if (imem_chipselect) imem_readdata <= 32'hA000_0000 + {22'd0, imem_address};

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return 32'hA000_0000 + ((pc >> 2) & 32'h0000_03FF);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] tgt,
                                 input logic rst);
        @(posedge clk_clk);
        #1;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        reset_reset    = rst;
    endtask

    // Reference model: the decode-visible stream is an unbroken PC sequence from
    // the latest reset or redirect, or a single fault entry for a misaligned target.
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            expQ.delete();
            streamPc  = 32'h0;
            issuePc   = 32'h0;
            halted    = 1'b0;
            pendFirst = 1'b1;
            firstDue  = 2;
            prevStall = 1'b0;
        end else begin
            if (redirect_valid || halted)
                checkOutput("csBlocked", 32'(imem_chipselect), 32'd0);
            else if (imem_chipselect) begin
                checkOutput("imemAddr", 32'(imem_address), 32'(issuePc[11:2]));
                issuePc = issuePc + 32'd4;
            end

            if (stallWindow && cyc >= 5 && cyc <= 9)
                checkOutput("stallCs", 32'(imem_chipselect), 32'd0);

            if (prevStall) begin
                checkOutput("holdValid", 32'(out_valid), 32'd1);
                checkOutput("holdPc", out_pc, savedPc);
                checkOutput("holdInstr", out_instr, savedInstr);
                checkOutput("holdFault", 32'(out_fault), 32'(savedFault));
            end

            if (pendFirst) begin
                if (out_valid) begin
                    checkOutput("firstLatency", 32'(cyc), 32'(firstDue));
                    pendFirst = 1'b0;
                end else if (cyc > firstDue) begin
                    checkOutput("firstLatency", 32'(cyc), 32'(firstDue));
                    pendFirst = 1'b0;
                end
            end

            if (out_valid && out_ready) begin
                if (expQ.size() == 0 && !halted) begin
                    expQ.push_back('{pc: streamPc, instr: instrOf(streamPc), fault: 1'b0});
                    streamPc = streamPc + 32'd4;
                end
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedXfer", out_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("outPc", out_pc, e.pc);
                    checkOutput("outInstr", out_instr, e.instr);
                    checkOutput("outFault", 32'(out_fault), 32'(e.fault));
                end
            end

            if (redirect_valid) begin
                expQ.delete();
                pendFirst = 1'b1;
                issuePc   = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) begin
                    halted   = 1'b1;
                    firstDue = cyc + 2;
                    expQ.push_back('{pc: redirect_pc, instr: 32'h0000_0013, fault: 1'b1});
                end else begin
                    halted   = 1'b0;
                    firstDue = cyc + 3;
                    streamPc = redirect_pc;
                end
            end

            prevStall  = out_valid && !out_ready && !redirect_valid;
            savedPc    = out_pc;
            savedInstr = out_instr;
            savedFault = out_fault;
        end
    end

    initial begin
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        reset_reset    = 1'b1;
        stallWindow    = 1'b1;

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk_clk);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstCs", 32'(imem_chipselect), 32'd0);
        checkOutput("rstPc", out_pc, 32'h0);
        checkOutput("rstInstr", out_instr, 32'h0);
        checkOutput("rstFault", 32'(out_fault), 32'd0);
        checkOutput("tieClken", 32'(imem_clken), 32'd1);
        checkOutput("tieWrite", 32'(imem_write), 32'd0);
        checkOutput("tieDbg", 32'(imem_debugaccess), 32'd0);
        checkOutput("tieBe", 32'(imem_byteenable), 32'hF);
        checkOutput("tieWdata", imem_writedata, 32'h0);

        for (int i = 0; i < 5; i++)  applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 5; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 10; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        stallWindow = 1'b0;

        // Fill the buffer, then redirect while entries are still pending.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'h0000_0102, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'h0000_0FFC, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic        rst, redir, rdy;
            logic [31:0] tgt;
            rst   = ($urandom_range(0, 299) == 0);
            redir = !rst && ($urandom_range(0, halted ? 5 : 24) == 0);
            rdy   = ($urandom_range(0, 9) < 7);
            tgt   = $urandom_range(0, 32'h1200) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'h0000_0FF0 + ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 5) == 0) tgt = tgt | $urandom_range(1, 3);
            applyStimulus(rdy, redir, tgt, rst);
        end

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
